alu_exec_unit: RTL and testbench

Parametrised execute-stage unit for the Abejaruco core. It replaces the fixed single-cycle ALU and the hard-wired 5-cycle multiply with one unit that has:
- a valid/ready handshake on both sides;
- configurable word width and multiply latency;
- a one-entry output register with backpressure;
- a synchronous flush for squashing in-flight work.

It sits between decode/issue and the commit/writeback multiplexer, and drives `rf_write_data` through its result port.

---
 rtl/alu_exec_unit_pkg.sv | 31 +++
 rtl/alu_exec_unit_mul_unit.sv | 52 +++++
 rtl/alu_exec_unit.sv | 153 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared op codes, FSM encoding and default widths for the execute-stage ALU.
// Any block that decodes or issues ALU ops imports this package.
package alu_exec_unit_pkg;

    localparam int DEFAULT_WORD_WIDTH  = 32;
    localparam int DEFAULT_MUL_LATENCY = 5;
    localparam int DEFAULT_TAG_WIDTH   = 5;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SLT  = 3'b110,
        OP_SLTU = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_RUN  = 2'd1,
        ST_MUL_WAIT = 2'd2
    } exec_state_e;

    // Width of the multiply countdown; never zero, even for a 1-cycle multiply.
    function automatic int mul_cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul_unit.sv
// Multi-cycle multiplier: latches operands on start and raises done once the
// countdown expires. The product stays valid until the next start.
module mul_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] product
);

    localparam int CW = mul_cnt_width(MUL_LATENCY);
    // The accept edge is the first of the MUL_LATENCY edges, so the count
    // starts two below the latency and done is seen on the final edge.
    localparam logic [CW-1:0] CNT_LOAD = CW'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

    logic [WORD_WIDTH-1:0] a_q;
    logic [WORD_WIDTH-1:0] b_q;
    logic [CW-1:0]         cnt_q;
    logic                  run_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            cnt_q <= CNT_LOAD;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign done    = run_q && (cnt_q == '0);
    assign product = a_q * b_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage unit: single-cycle ALU ops inline, multi-cycle multiply via
// mul_unit, one-entry output register with valid/ready backpressure and flush.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int TAG_WIDTH   = DEFAULT_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [WORD_WIDTH-1:0] in_a,
    input  logic [WORD_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  busy
);

    exec_state_e           state_q, state_d;
    logic                  out_valid_q;
    logic [WORD_WIDTH-1:0] out_result_q;
    logic [TAG_WIDTH-1:0]  out_tag_q;
    logic [TAG_WIDTH-1:0]  mul_tag_q;

    logic                  out_free;
    logic                  accept;
    logic                  is_mul;
    logic                  mul_start;
    logic                  mul_done;
    logic [WORD_WIDTH-1:0] mul_product;
    logic [WORD_WIDTH-1:0] alu_result;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] wr_result;
    logic [TAG_WIDTH-1:0]  wr_tag;

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_IDLE) && out_free && !flush;
    assign accept    = in_valid && in_ready;
    assign is_mul    = (in_op == OP_MUL);
    assign mul_start = accept && is_mul && (MUL_LATENCY > 1);

    mul_unit #(
        .WORD_WIDTH (WORD_WIDTH),
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .start  (mul_start),
        .a      (in_a),
        .b      (in_b),
        .done   (mul_done),
        .product(mul_product)
    );

    // The MUL entry only matters when the latency is 1; longer multiplies
    // take their product from mul_unit.
    always_comb begin
        alu_result = '0;
        case (alu_op_e'(in_op))
            OP_ADD:  alu_result = in_a + in_b;
            OP_SUB:  alu_result = in_a - in_b;
            OP_MUL:  alu_result = in_a * in_b;
            OP_AND:  alu_result = in_a & in_b;
            OP_OR:   alu_result = in_a | in_b;
            OP_XOR:  alu_result = in_a ^ in_b;
            OP_SLT:  alu_result = {{(WORD_WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: alu_result = {{(WORD_WIDTH-1){1'b0}}, (in_a < in_b)};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_result = alu_result;
        wr_tag    = in_tag;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mul_start) begin
                        state_d = ST_MUL_RUN;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            ST_MUL_RUN: begin
                if (mul_done) begin
                    if (out_free) begin
                        wr_en     = 1'b1;
                        wr_result = mul_product;
                        wr_tag    = mul_tag_q;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_MUL_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (out_ready) begin
                    wr_en     = 1'b1;
                    wr_result = mul_product;
                    wr_tag    = mul_tag_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A squash discards whatever would have been written this edge.
        if (flush) begin
            state_d = ST_IDLE;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            mul_tag_q    <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start) begin
                mul_tag_q <= in_tag;
            end
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (wr_en) begin
                out_valid_q  <= 1'b1;
                out_result_q <= wr_result;
                out_tag_q    <= wr_tag;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit: a 32-bit/5-cycle instance
// and a 16-bit/1-cycle instance, both checked against a cycle-level model.
`timescale 1ns/1ps
module tb_alu_exec_unit;

    localparam int L0 = 5;
    localparam int L1 = 1;
    localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_MUL = 3'd2, C_AND = 3'd3;
    localparam logic [2:0] C_OR = 3'd4, C_XOR = 3'd5, C_SLT = 3'd6, C_SLTU = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        iv0 = 1'b0, fl0 = 1'b0, or0 = 1'b1;
    logic [2:0]  op0 = '0;
    logic [31:0] ia0 = '0, ib0 = '0;
    logic [4:0]  it0 = '0;
    logic        rdy0, ov0, bz0;
    logic [31:0] res0;
    logic [4:0]  ot0;

    logic        iv1 = 1'b0, fl1 = 1'b0, or1 = 1'b1;
    logic [2:0]  op1 = '0;
    logic [15:0] ia1 = '0, ib1 = '0;
    logic [4:0]  it1 = '0;
    logic        rdy1, ov1, bz1;
    logic [15:0] res1;
    logic [4:0]  ot1;

    alu_exec_unit #(.WORD_WIDTH(32), .MUL_LATENCY(L0), .TAG_WIDTH(5)) dut0 (
        .clk(clk), .reset(reset), .flush(fl0), .in_valid(iv0), .in_ready(rdy0),
        .in_op(op0), .in_a(ia0), .in_b(ib0), .in_tag(it0), .out_valid(ov0),
        .out_ready(or0), .out_result(res0), .out_tag(ot0), .busy(bz0)
    );

    alu_exec_unit #(.WORD_WIDTH(16), .MUL_LATENCY(L1), .TAG_WIDTH(5)) dut1 (
        .clk(clk), .reset(reset), .flush(fl1), .in_valid(iv1), .in_ready(rdy1),
        .in_op(op1), .in_a(ia1), .in_b(ib1), .in_tag(it1), .out_valid(ov1),
        .out_ready(or1), .out_result(res1), .out_tag(ot1), .busy(bz1)
    );

    // Reference model: held result, plus a pending multiply with edges left.
    bit          m_ov[2];
    bit          m_act[2];
    bit          m_wait[2];
    int          m_left[2];
    logic [31:0] m_res[2];
    logic [31:0] m_mres[2];
    logic [4:0]  m_tag[2];
    logic [4:0]  m_mtag[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        logic [63:0] m, ua, ub, r;
        longint sa, sb;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & m;
        ub = {32'd0, b} & m;
        sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        case (op)
            C_ADD:   r = ua + ub;
            C_SUB:   r = ua - ub;
            C_MUL:   r = ua * ub;
            C_AND:   r = ua & ub;
            C_OR:    r = ua | ub;
            C_XOR:   r = ua ^ ub;
            C_SLT:   r = (sa < sb) ? 64'd1 : 64'd0;
            default: r = (ua < ub) ? 64'd1 : 64'd0;
        endcase
        return 32'(r & m);
    endfunction

    function automatic bit exp_ready(input int d, input bit ordy, input bit fl);
        return !(m_act[d] || m_wait[d]) && (!m_ov[d] || ordy) && !fl;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ov[i] = 0; m_act[i] = 0; m_wait[i] = 0; m_left[i] = 0;
            m_res[i] = '0; m_tag[i] = '0;
        end
    endtask

    task automatic model_step(input int d, input bit v, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] tg, input bit ordy,
                              input bit fl, input bit rdy);
        bit          wr = 0;
        logic [31:0] wres = '0;
        logic [4:0]  wtag = '0;
        int          w = (d == 0) ? 32 : 16;
        int          lat = (d == 0) ? L0 : L1;
        if (fl) begin
            m_ov[d] = 0; m_act[d] = 0; m_wait[d] = 0;
            return;
        end
        if (m_act[d]) begin
            if (m_left[d] > 1) begin
                m_left[d]--;
            end else begin
                m_act[d] = 0;
                if (!m_ov[d] || ordy) begin wr = 1; wres = m_mres[d]; wtag = m_mtag[d]; end
                else m_wait[d] = 1;
            end
        end else if (m_wait[d]) begin
            if (ordy) begin wr = 1; wres = m_mres[d]; wtag = m_mtag[d]; m_wait[d] = 0; end
        end else if (v && rdy) begin
            if (op == C_MUL && lat > 1) begin
                m_act[d] = 1; m_left[d] = lat - 1;
                m_mres[d] = ref_alu(op, a, b, w); m_mtag[d] = tg;
            end else begin
                wr = 1; wres = ref_alu(op, a, b, w); wtag = tg;
            end
        end
        if (wr) begin m_ov[d] = 1; m_res[d] = wres; m_tag[d] = wtag; end
        else if (ordy) m_ov[d] = 0;
    endtask

    task automatic check_outputs(input int d);
        logic ov, bz;
        logic [31:0] r;
        logic [4:0] t;
        if (d == 0) begin ov = ov0; bz = bz0; r = res0; t = ot0; end
        else begin ov = ov1; bz = bz1; r = {16'd0, res1}; t = ot1; end
        check("out_valid", 32'(ov), 32'(m_ov[d]));
        check("busy", 32'(bz), 32'(m_act[d] || m_wait[d]));
        if (m_ov[d]) begin
            check("out_result", r, m_res[d]);
            check("out_tag", 32'(t), 32'(m_tag[d]));
        end
    endtask

    // One clock: check outputs, drive dut d (the other idles), check ready, step model.
    task automatic cycle(input int d, input bit v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tg, input bit ordy,
                         input bit fl, input bit rst);
        bit v_[2], r_[2], f_[2], er[2];
        check_outputs(d);
        for (int i = 0; i < 2; i++) begin
            v_[i] = (i == d) ? v : 1'b0;
            r_[i] = (i == d) ? ordy : 1'b1;
            f_[i] = (i == d) ? fl : 1'b0;
        end
        iv0 = v_[0]; or0 = r_[0]; fl0 = f_[0]; op0 = op; ia0 = a; ib0 = b; it0 = tg;
        iv1 = v_[1]; or1 = r_[1]; fl1 = f_[1]; op1 = op; ia1 = a[15:0]; ib1 = b[15:0]; it1 = tg;
        reset = rst;
        #1;
        for (int i = 0; i < 2; i++) er[i] = exp_ready(i, r_[i], f_[i]);
        if (!rst) check("in_ready", (d == 0) ? 32'(rdy0) : 32'(rdy1), 32'(er[d]));
        @(posedge clk);
        if (rst) model_reset();
        else for (int i = 0; i < 2; i++) model_step(i, v_[i], op, a, b, tg, r_[i], f_[i], er[i]);
        if (!rst && v && er[d])
            $display("txn dut=%0d op=%0d a=%h b=%h tag=%0d", d, op, a, b, tg);
        @(negedge clk);
    endtask

    task automatic idle(input int d, input bit ordy, input int n);
        for (int k = 0; k < n; k++) cycle(d, 0, C_ADD, 0, 0, 0, ordy, 0, 0);
    endtask

    // Issue one op and wait (bounded) for its result, then compare with a constant.
    task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string nm);
        int n = 0;
        cycle(d, 1, op, a, b, 5'd7, 1, 0, 0);
        while (((d == 0) ? ov0 : ov1) !== 1'b1 && n < 10) begin
            cycle(d, 0, C_ADD, 0, 0, 0, 1, 0, 0);
            n++;
        end
        check({nm, "_valid"}, (d == 0) ? 32'(ov0) : 32'(ov1), 32'd1);
        check(nm, (d == 0) ? res0 : {16'd0, res1}, exp);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int d;
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_valid", 32'(ov0), 32'd0);
        check("rst_result", res0, 32'd0);
        check("rst_tag", 32'(ot0), 32'd0);
        check("rst_busy", 32'(bz0), 32'd0);
        check("rst_ready", 32'(rdy0), 32'd1);

        // ADD 2+1, tag 4
        cycle(0, 1, C_ADD, 2, 1, 4, 1, 0, 0);
        check("add_res", res0, 32'd3);
        check("add_tag", 32'(ot0), 32'd4);

        // MUL 2*1 tag 3, with SUB held waiting behind it
        cycle(0, 1, C_MUL, 2, 1, 3, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            check("mul_busy", 32'(bz0), 32'd1);
            cycle(0, 1, C_SUB, 2, 1, 5, 1, 0, 0);
        end
        check("mul_res", res0, 32'd2);
        check("mul_tag", 32'(ot0), 32'd3);
        cycle(0, 1, C_SUB, 2, 1, 5, 1, 0, 0);
        check("sub_res", res0, 32'd1);
        check("sub_tag", 32'(ot0), 32'd5);

        // Backpressure: ADD held while MUL waits, then MUL 3*3
        idle(0, 1, 1);
        cycle(0, 1, C_ADD, 2, 1, 6, 0, 0, 0);
        cycle(0, 1, C_MUL, 3, 3, 9, 0, 0, 0);
        cycle(0, 1, C_MUL, 3, 3, 9, 0, 0, 0);
        check("hold_res", res0, 32'd3);
        check("hold_tag", 32'(ot0), 32'd6);
        cycle(0, 1, C_MUL, 3, 3, 9, 1, 0, 0);
        idle(0, 0, 4);
        check("bp_mul_res", res0, 32'd9);
        check("bp_mul_tag", 32'(ot0), 32'd9);
        idle(0, 1, 1);

        // Flush two cycles after a MUL accept
        cycle(0, 1, C_MUL, 5, 5, 2, 1, 0, 0);
        idle(0, 1, 1);
        cycle(0, 0, C_ADD, 0, 0, 0, 1, 1, 0);
        check("flush_busy", 32'(bz0), 32'd0);
        idle(0, 1, 6);
        check("flush_no_valid", 32'(ov0), 32'd0);

        // Reset in the middle of a multiply
        cycle(0, 1, C_MUL, 7, 7, 1, 1, 0, 0);
        idle(0, 1, 1);
        cycle(0, 0, C_ADD, 0, 0, 0, 1, 0, 1);
        idle(0, 1, 6);
        check("rst_mul_no_valid", 32'(ov0), 32'd0);

        // Arithmetic edge cases, 32 bits
        run_op(0, C_SLT, 32'hFFFF_FFFF, 1, 32'd1, "slt32");
        run_op(0, C_SLTU, 32'hFFFF_FFFF, 1, 32'd0, "sltu32");
        run_op(0, C_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, "mulwrap32");
        run_op(0, C_ADD, 32'hFFFF_FFFF, 1, 32'd0, "addwrap32");

        // Same at 16 bits with a single-cycle multiply
        run_op(1, C_SLT, 32'h0000_FFFF, 1, 32'd1, "slt16");
        run_op(1, C_SLTU, 32'h0000_FFFF, 1, 32'd0, "sltu16");
        run_op(1, C_MUL, 32'h0000_0100, 32'h0000_0100, 32'd0, "mulwrap16");
        run_op(1, C_ADD, 32'h0000_FFFF, 1, 32'd0, "addwrap16");
        cycle(1, 1, C_MUL, 3, 5, 2, 1, 0, 0);
        check("l1_mul_valid", 32'(ov1), 32'd1);
        check("l1_mul_res", {16'd0, res1}, 32'd15);
        check("l1_busy", 32'(bz1), 32'd0);

        // Random traffic with backpressure and occasional flush
        for (int i = 0; i < 800; i++) begin
            d = (i < 400) ? 0 : 1;
            cycle(d, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), rand_operand(),
                  rand_operand(), 5'($urandom_range(0, 31)), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 49) == 0, 1'b0);
        end
        check_outputs(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
